button_irq_ctrl: RTL and testbench

BUTTON_IRQ_CTRL -- requirements
Module: button_irq_ctrl

---
 rtl/button_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_button_irq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/button_irq_ctrl.sv
// Push-button interrupt controller: synchronizes and debounces an active-low key,
// captures filtered edges and raises a maskable level interrupt behind a 4-word slave.
module button_irq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        button_export,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             btn_sync;
  logic             btn_db;
  logic             btn_db_d;
  logic [CNT_W-1:0] cnt;
  logic             edgecapture;
  logic             irqmask;
  logic             fall_event;
  logic             rise_event;
  logic             edge_event;
  logic             clear_wr;
  logic             mask_wr;
  logic             rd_en;
  logic [31:0]      rd_mux;

  // Only bit 0 of the write data carries meaning.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata[31:1]};

  // Synchronizer and debouncer idle high so reset release never looks like a press.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= 1'b1;
      btn_sync  <= 1'b1;
    end else begin
      sync_meta <= button_export;
      btn_sync  <= sync_meta;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      btn_db <= 1'b1;
      cnt    <= '0;
    end else if (btn_sync == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      btn_db <= btn_sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      btn_db_d <= 1'b1;
    end else begin
      btn_db_d <= btn_db;
    end
  end

  assign fall_event = btn_db_d & ~btn_db;
  assign rise_event = ~btn_db_d & btn_db;

  always_comb begin
    edge_event = fall_event | rise_event;
    case (EDGE_TYPE)
      0:       edge_event = fall_event;
      1:       edge_event = rise_event;
      default: edge_event = fall_event | rise_event;
    endcase
  end

  assign clear_wr = avs_chipselect & avs_write & (avs_address == 2'd3);
  assign mask_wr  = avs_chipselect & avs_write & (avs_address == 2'd2);
  assign rd_en    = avs_chipselect & avs_read;

  // A new edge takes priority over a simultaneous clear so no event is lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edgecapture <= 1'b0;
    end else if (edge_event) begin
      edgecapture <= 1'b1;
    end else if (clear_wr) begin
      edgecapture <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irqmask <= 1'b0;
    end else if (mask_wr) begin
      irqmask <= avs_writedata[0];
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      2'd0:    rd_mux = {31'd0, btn_db};
      2'd2:    rd_mux = {31'd0, irqmask};
      2'd3:    rd_mux = {31'd0, edgecapture};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= 32'd0;
    end else if (rd_en) begin
      avs_readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= edgecapture & irqmask;
    end
  end

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Directed bench for button_irq_ctrl with DEBOUNCE_CYCLES=4, EDGE_TYPE=0 (falling edge).
module tb_button_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        button;
  logic [1:0]  addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  button_irq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .button_export (button),
    .avs_address   (addr),
    .avs_chipselect(cs),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [31:0] expected, input string tag);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    check(tag, rdata, expected);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0; wdata = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0; button = 1'b1; addr = 2'd0; cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = 32'd0;
    repeat (3) tick();
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Reset values
    reg_read(2'd0, 32'h1, "idle_btn");
    reg_read(2'd2, 32'h0, "idle_mask");
    reg_read(2'd3, 32'h0, "idle_cap");
    check("idle_irq", {31'd0, irq}, 32'd0);

    // Held press with the mask set: btn_db falls on the 6th edge, capture on 7th, irq on 8th
    reg_write(2'd2, 32'h1);
    button = 1'b0;
    cs = 1'b1; rd = 1'b1; addr = 2'd0;
    repeat (5) tick();
    check("press_e5_btn", rdata, 32'h1);
    tick();
    check("press_e6_btn", rdata, 32'h1);
    addr = 2'd3;
    tick();
    check("press_e7_cap", rdata, 32'h0);
    check("press_e7_irq", {31'd0, irq}, 32'd0);
    addr = 2'd0;
    tick();
    check("press_e8_btn", rdata, 32'h0);
    check("press_e8_irq", {31'd0, irq}, 32'd1);
    addr = 2'd3;
    tick();
    check("press_cap", rdata, 32'h1);
    tick();
    check("cap_reread", rdata, 32'h1);
    cs = 1'b0; rd = 1'b0; addr = 2'd1;
    tick();
    check("rdata_hold", rdata, 32'h1);
    reg_read(2'd1, 32'h0, "addr1_zero");

    // Clear with irq pending, then a release must not capture
    reg_write(2'd3, 32'h0);
    check("clr_irq_e1", {31'd0, irq}, 32'd1);
    tick();
    check("clr_irq_e2", {31'd0, irq}, 32'd0);
    button = 1'b1;
    repeat (8) tick();
    reg_read(2'd3, 32'h0, "release_cap");
    reg_read(2'd0, 32'h1, "release_btn");
    check("release_irq", {31'd0, irq}, 32'd0);

    // Three-clock glitch is rejected
    button = 1'b0;
    repeat (3) tick();
    button = 1'b1;
    repeat (8) tick();
    reg_read(2'd0, 32'h1, "glitch_btn");
    reg_read(2'd3, 32'h0, "glitch_cap");
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Writes to address 0/1 are ignored
    reg_write(2'd0, 32'hFFFF_FFFE);
    reg_write(2'd1, 32'hFFFF_FFFF);
    reg_read(2'd0, 32'h1, "wr0_ignored");
    reg_read(2'd2, 32'h1, "mask_kept");

    // Clear on the same clock as the edge detect: the set wins
    reg_write(2'd2, 32'h0);
    button = 1'b0;
    repeat (6) tick();
    cs = 1'b1; wr = 1'b1; addr = 2'd3;
    tick();
    cs = 1'b0; wr = 1'b0;
    check("race_irq", {31'd0, irq}, 32'd0);
    reg_read(2'd3, 32'h1, "race_cap");
    check("masked_irq", {31'd0, irq}, 32'd0);
    reg_write(2'd2, 32'h1);
    check("unmask_irq_e1", {31'd0, irq}, 32'd0);
    tick();
    check("unmask_irq_e2", {31'd0, irq}, 32'd1);

    // Reset mid-debounce (cnt=2) with irq pending
    button = 1'b1;
    repeat (4) tick();
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_rdata", rdata, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rdata", rdata, 32'd0);
    check("async_irq", {31'd0, irq}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    reg_read(2'd0, 32'h1, "post_btn");
    reg_read(2'd2, 32'h0, "post_mask");
    reg_read(2'd3, 32'h0, "post_cap");
    check("post_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
